// File: rtl/imem_responder.sv
// imem_responder
//   Instruction-memory responder for a fetch stage. It accepts one byte
//   address at a time, waits WAIT cycles, then holds a registered response
//   until the fetch stage consumes it. A new request can be accepted on the
//   same edge that consumes a response, so there is no idle bubble. A
//   program-load write port fills the memory in any FSM state.
//
// Parameters
//   N      request address width in bits
//   DEPTH  memory size in 32-bit words
//   WAIT   wait-state cycles per access (0..15)
//
// Ports
//   clk        sole clock, rising edge
//   reset      asynchronous, active-low reset (memory contents are kept)
//   req_valid  fetch stage presents req_addr
//   req_addr   byte address of the requested instruction
//   req_ready  request accepted on this edge if req_valid is high
//   rsp_valid  rsp_instr / rsp_addr / rsp_err are valid
//   rsp_ready  fetch stage consumes the response
//   rsp_instr  instruction word (0 on error)
//   rsp_addr   address that produced this response
//   rsp_err    misaligned or out-of-range access
//   prog_we    program-load write enable
//   prog_addr  word index for program load
//   prog_data  word to write
module imem_responder #(
    parameter int N     = 64,
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [N-1:0]             req_addr,
    output logic                     req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_instr,
    output logic [N-1:0]             rsp_addr,
    output logic                     rsp_err,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [31:0]              prog_data
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t         state;
    logic [3:0]     cnt_p0;
    logic [N-1:0]   addr_p0;
    logic [31:0]    mem [DEPTH];

    // Misaligned byte address or word index beyond the memory.
    function automatic logic addr_err(input logic [N-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= N'(DEPTH));
    endfunction

    // Word index used for the memory read; only meaningful when addr_err is 0.
    function automatic logic [AW-1:0] word_idx(input logic [N-1:0] a);
        return a[AW+1:2];
    endfunction

    // Program load. No reset: contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // The response may be consumed and a new request accepted on one edge.
    assign req_ready = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready);

    // Request capture -> wait countdown -> registered response.
    // The memory read below samples mem before any write on the same edge,
    // so a program-load write to the word being fetched returns the old word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt_p0    <= 4'd0;
            addr_p0   <= '0;
            rsp_valid <= 1'b0;
            rsp_instr <= 32'h0;
            rsp_addr  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_p0 <= req_addr;
                        cnt_p0  <= 4'(WAIT);
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_p0 == 4'd0) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_addr  <= addr_p0;
                        rsp_err   <= addr_err(addr_p0);
                        rsp_instr <= addr_err(addr_p0) ? 32'h0 : mem[word_idx(addr_p0)];
                    end else begin
                        cnt_p0 <= cnt_p0 - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (req_valid) begin
                            addr_p0 <= req_addr;
                            cnt_p0  <= 4'(WAIT);
                            state   <= ST_WAIT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 The block SHALL have parameter N, default 64, meaning request address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 64, meaning instruction memory size in 32-bit words.
REQ-003 The block SHALL have parameter WAIT, default 2, meaning wait-state cycles per access (0 to 15).
REQ-004 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port req_valid  input  1  fetch stage presents an address.
REQ-007 The block SHALL have port req_addr  input  N  byte address of the requested instruction.
REQ-008 The block SHALL have port req_ready  output  1  request accepted on this edge if req_valid is high.
REQ-009 The block SHALL have port rsp_valid  output  1  response fields valid.
REQ-010 The block SHALL have port rsp_ready  input  1  fetch stage consumes the response.
REQ-011 The block SHALL have port rsp_instr  output  32  instruction word.
REQ-012 The block SHALL have port rsp_addr  output  N  address that produced this response.
REQ-013 The block SHALL have port rsp_err  output  1  misaligned or out-of-range access.
REQ-014 The block SHALL have port prog_we  input  1  program-load write enable.
REQ-015 The block SHALL have port prog_addr  input  $clog2(DEPTH)  word index for program load.
REQ-016 The block SHALL have port prog_data  input  32  word to write.

Function
REQ-017 The block SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-018 In IDLE, req_ready SHALL be 1; on req_valid at an edge, the block SHALL capture req_addr, load the wait counter with WAIT, and enter WAIT.
REQ-019 In WAIT, if the counter is 0 the block SHALL enter RESP; otherwise it SHALL decrement the counter, giving rsp_valid high after edge k+1+WAIT for an accept at edge k.
REQ-020 On the WAIT->RESP edge the block SHALL register rsp_instr = mem[req_addr[..:2]], rsp_addr = captured address, rsp_err = error flag.
REQ-021 The error flag SHALL be 1 when captured address bits [1:0] != 0 or word index (bits [N-1:2]) >= DEPTH; then rsp_instr SHALL be 32'h0.
REQ-022 In RESP, rsp_valid SHALL be 1 and rsp_instr/rsp_addr/rsp_err SHALL stay stable until rsp_valid && rsp_ready.
REQ-023 req_ready SHALL equal (state==IDLE) || (state==RESP && rsp_ready); it SHALL be 0 in WAIT.
REQ-024 On response handshake with req_valid high in the same cycle, the block SHALL accept the new request and enter WAIT (back-to-back, no IDLE bubble).
REQ-025 On response handshake with req_valid low, the block SHALL return to IDLE and drive rsp_valid 0.
REQ-026 prog_we SHALL write prog_data to mem[prog_addr] on the rising edge, in any FSM state.
REQ-027 A write to the word being read on the same WAIT->RESP edge SHALL NOT be visible (old data returned); writes on earlier edges SHALL be visible.
REQ-028 req_addr changes while in WAIT or RESP SHALL NOT affect the pending response.

Reset
REQ-029 reset low SHALL force, asynchronously, state IDLE, counter 0, rsp_valid 0, rsp_instr 0, rsp_addr 0, rsp_err 0.
REQ-030 Reset asserted mid-WAIT or mid-RESP SHALL abort the access; no response SHALL appear after release.
REQ-031 Memory contents SHALL NOT be cleared by reset.
REQ-032 After reset release, the first accepted request SHALL follow REQ-018 exactly.

Verification
REQ-033 Load mem[1]=32'hD503201F, WAIT=2, req_addr=0x4 accepted at edge k -> rsp_valid high after edge k+3, rsp_instr=D503201F, rsp_addr=0x4, rsp_err=0.
REQ-034 req_addr=0x6 -> rsp_err=1, rsp_instr=0; req_addr=DEPTH*4 -> rsp_err=1.
REQ-035 rsp_ready held low 5 cycles in RESP -> rsp fields unchanged, req_ready=0; raise rsp_ready with req_valid=1, addr 0x8 -> req_ready=1, next response for 0x8 after WAIT+1 more edges.
REQ-036 Sequential addresses 0x0,0x4,0x8 with rsp_ready=1 and WAIT=0 -> one response every 2 cycles, data in order, no IDLE cycle between.
REQ-037 Reset pulsed low during WAIT -> rsp_valid stays 0 after release until a new request; mem[1] still D503201F.
REQ-038 prog_we to the addressed word on the WAIT->RESP edge -> old word returned; re-fetch returns new word.
